// File: rtl/poseidon_input_packer.sv
// poseidon_input_packer: assembles IN_W-bit host words (little-endian word
// order) into ELEM_W-bit field elements and groups ELEMS elements per packet,
// flagging the final element with out_last. Output is an AXI-style
// valid/ready stream that holds steady until accepted.
// Optional build macro: PACKER_STATS_EN adds the pkt_count packet counter.
//
// state | meaning
// FILL  | collecting words of the current element
// HOLD  | completed element presented on out_*, waiting for out_ready
module poseidon_input_packer #(
  parameter int IN_W   = 64,
  parameter int ELEM_W = 255,
  parameter int ELEMS  = 3
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic [ELEM_W-1:0] out_payload,
  output logic              err_msb
`ifdef PACKER_STATS_EN
  ,
  output logic [15:0]       pkt_count
`endif
);

  localparam int WPE    = (ELEM_W + IN_W - 1) / IN_W;
  localparam int TOP_W  = ELEM_W - IN_W * (WPE - 1);
  localparam int WIDX_W = (WPE > 1) ? $clog2(WPE) : 1;
  localparam int EIDX_W = (ELEMS > 1) ? $clog2(ELEMS) : 1;
  localparam logic [WIDX_W-1:0] WIDX_LAST = WIDX_W'(WPE - 1);
  localparam logic [EIDX_W-1:0] EIDX_LAST = EIDX_W'(ELEMS - 1);

  typedef enum logic {FILL, HOLD} state_t;

  state_t              state, state_nxt;
  logic [WIDX_W-1:0]   word_idx;
  logic [EIDX_W-1:0]   elem_idx, elem_inc, elem_load;
  logic [ELEM_W-1:0]   acc, acc_nxt;
  logic                in_hs, out_hs, last_word, load, hi_bad;

  // A HOLD can only accept a word while the element is leaving the same cycle,
  // so an in-handshake in HOLD always coincides with an out-handshake.
  assign in_ready  = resetn & ((state == FILL) | ((state == HOLD) & out_ready));
  assign in_hs     = in_valid & in_ready;
  assign out_hs    = out_valid & out_ready;
  assign last_word = (word_idx == WIDX_LAST);
  assign load      = in_hs & last_word;
  assign elem_inc  = (elem_idx == EIDX_LAST) ? '0 : elem_idx + 1'b1;
  // Index of the element being completed: advances first if the presented
  // element is accepted in the same cycle (only possible when WPE == 1).
  assign elem_load = out_hs ? elem_inc : elem_idx;

  // Merge the incoming word into the accumulator; the top word is truncated
  // to the element width and any discarded set bit is reported.
  always_comb begin
    acc_nxt = acc;
    for (int k = 0; k < WPE - 1; k++) begin
      if (word_idx == WIDX_W'(k)) acc_nxt[IN_W*k +: IN_W] = in_data;
    end
    if (last_word) acc_nxt[ELEM_W-1 -: TOP_W] = in_data[TOP_W-1:0];
    hi_bad = last_word & (|(in_data >> TOP_W));
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!resetn) state <= FILL;
    else         state <= state_nxt;
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      FILL:    if (load) state_nxt = HOLD;
      HOLD:    if (out_hs) state_nxt = load ? HOLD : FILL;
      default: state_nxt = FILL;
    endcase
  end

  // Word/element counters, accumulator, output element register and error flag.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      word_idx    <= '0;
      elem_idx    <= '0;
      acc         <= '0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      out_payload <= '0;
      err_msb     <= 1'b0;
    end else begin
      if (in_hs) begin
        acc      <= acc_nxt;
        word_idx <= last_word ? '0 : word_idx + 1'b1;
        if (hi_bad) err_msb <= 1'b1;
      end
      if (out_hs) elem_idx <= elem_inc;
      if (load) begin
        out_valid   <= 1'b1;
        out_payload <= acc_nxt;
        out_last    <= (elem_load == EIDX_LAST);
      end else if (out_hs) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

`ifdef PACKER_STATS_EN
  // Completed-packet counter, wraps at 16 bits.
  always_ff @(posedge clk) begin
    if (!resetn)               pkt_count <= '0;
    else if (out_hs & out_last) pkt_count <= pkt_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_poseidon_input_packer.sv
// Directed bench for poseidon_input_packer: a vector table for one packet
// (including a discarded-MSB word), then hand-written backpressure,
// throughput and mid-packet reset sequences, with a stream model on the side.
module tb_poseidon_input_packer;

  logic         clk = 1'b0;
  logic         resetn;
  logic         in_valid;
  logic         in_ready;
  logic [63:0]  in_data;
  logic         out_valid;
  logic         out_ready;
  logic         out_last;
  logic [254:0] out_payload;
  logic         err_msb;
`ifdef PACKER_STATS_EN
  logic [15:0]  pkt_count;
`endif

  int checks = 0;
  int errors = 0;
  int n_out  = 0;
  int n_last = 0;

  always #5 clk = ~clk;

  poseidon_input_packer dut (
    .clk         (clk),
    .resetn      (resetn),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last),
    .out_payload (out_payload),
    .err_msb     (err_msb)
`ifdef PACKER_STATS_EN
    ,
    .pkt_count   (pkt_count)
`endif
  );

  typedef struct {
    logic         vld;
    logic [63:0]  data;
    logic         ordy;
    logic         exp_in_ready;
    logic         exp_ovalid;
    logic         exp_olast;
    logic         exp_err;
    logic [254:0] exp_payload;
  } vec_t;

  task automatic chk(input string name, input logic [254:0] act, input logic [254:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [254:0] pl(input logic [63:0] w0, w1, w2, w3);
    return {w3[62:0], w2, w1, w0};
  endfunction

  function automatic logic [63:0] tw(input int e, input int k);
    if (e == 1 && k == 3) return 64'h8000_0000_0000_0001;
    return {8'(e + 1), 8'(k + 1), 48'h0123_4567_89AB};
  endfunction

  function automatic logic [63:0] bw(input int e, input int k);
    return {8'(8'hB0 + e), 8'(k), 48'h0000_0000_0001};
  endfunction

  function automatic logic [63:0] tpw(input int n);
    return {32'(n), 32'(n * 7 + 3)};
  endfunction

  // Stream model: rebuilds expected elements from accepted words and checks
  // every accepted output element against them, in order.
  logic [255:0] exp_q[$];
  logic [63:0]  wbuf[4];
  int           mw = 0;
  int           me = 0;
  always @(negedge clk) begin
    if (!resetn) begin
      mw = 0;
      me = 0;
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        n_out++;
        if (out_last) n_last++;
        chk("mon_have_expected", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          logic [255:0] p;
          p = exp_q.pop_front();
          chk("mon_payload", out_payload, p[254:0]);
          chk("mon_last", out_last, p[255]);
        end
      end
      if (in_valid && in_ready) begin
        wbuf[mw] = in_data;
        mw++;
        if (mw == 4) begin
          exp_q.push_back({me == 2, pl(wbuf[0], wbuf[1], wbuf[2], wbuf[3])});
          me = (me == 2) ? 0 : me + 1;
          mw = 0;
        end
      end
    end
  end

  task automatic cyc(input logic v, input logic [63:0] d, input logic r);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    cyc(1'b0, 64'd0, 1'b0);
    cyc(1'b0, 64'd0, 1'b0);
    resetn = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t         vecs[13];
    logic [254:0] bp_exp;
    int           n0, l0, n, cycles;

    for (int i = 0; i < 12; i++) begin
      int e, k;
      e = i / 4;
      k = i % 4;
      vecs[i].vld          = 1'b1;
      vecs[i].data         = tw(e, k);
      vecs[i].ordy         = 1'b1;
      vecs[i].exp_in_ready = 1'b1;
      vecs[i].exp_ovalid   = (k == 3);
      vecs[i].exp_olast    = (k == 3) && (e == 2);
      vecs[i].exp_err      = (i >= 7);
      vecs[i].exp_payload  = pl(tw(e, 0), tw(e, 1), tw(e, 2), tw(e, 3));
    end
    vecs[12] = '{1'b0, 64'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, '0};

    // Reset state, including in_ready low while reset is asserted.
    resetn    = 1'b0;
    in_valid  = 1'b1;
    in_data   = 64'hFFFF_FFFF_FFFF_FFFF;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_payload", out_payload, '0);
    chk("rst_err", err_msb, 1'b0);
`ifdef PACKER_STATS_EN
    chk("rst_pkt_count", pkt_count, '0);
`endif
    resetn = 1'b1;

    // Single packet from the vector table.
    for (int i = 0; i < 13; i++) begin
      in_valid  = vecs[i].vld;
      in_data   = vecs[i].data;
      out_ready = vecs[i].ordy;
      #1;
      chk($sformatf("vec%0d_in_ready", i), in_ready, vecs[i].exp_in_ready);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_out_valid", i), out_valid, vecs[i].exp_ovalid);
      chk($sformatf("vec%0d_out_last", i), out_last, vecs[i].exp_olast);
      chk($sformatf("vec%0d_err_msb", i), err_msb, vecs[i].exp_err);
      if (vecs[i].exp_ovalid)
        chk($sformatf("vec%0d_payload", i), out_payload, vecs[i].exp_payload);
      if (i == 7) chk("msb_trunc_top", out_payload[254:192], 63'd1);
    end

    // Backpressure on element 1 of a packet.
    n0 = n_out;
    l0 = n_last;
    bp_exp = pl(bw(1, 0), bw(1, 1), bw(1, 2), bw(1, 3));
    for (int e = 0; e < 2; e++)
      for (int k = 0; k < 4; k++) cyc(1'b1, bw(e, k), 1'b1);
    for (int c = 0; c < 5; c++) begin
      in_valid  = 1'b1;
      in_data   = 64'hDEAD_BEEF_DEAD_BEEF;
      out_ready = 1'b0;
      #1;
      chk("bp_in_ready", in_ready, 1'b0);
      @(posedge clk);
      #1;
      chk("bp_out_valid", out_valid, 1'b1);
      chk("bp_payload", out_payload, bp_exp);
      chk("bp_out_last", out_last, 1'b0);
    end
    for (int k = 0; k < 4; k++) cyc(1'b1, bw(2, k), 1'b1);
    chk("bp_last_elem_valid", out_valid, 1'b1);
    chk("bp_last_elem_last", out_last, 1'b1);
    cyc(1'b0, 64'd0, 1'b1);
    cyc(1'b0, 64'd0, 1'b1);
    chk("bp_elements", n_out - n0, 3);
    chk("bp_lasts", n_last - l0, 1);
    chk("bp_idle_valid", out_valid, 1'b0);

    // Back-to-back throughput: 100 packets.
    do_reset();
    n0 = n_out;
    l0 = n_last;
    n = 0;
    cycles = 0;
    while ((n < 1200 || (n_out - n0) < 300) && cycles < 2000) begin
      in_valid  = (n < 1200);
      in_data   = tpw(n);
      out_ready = 1'b1;
      #1;
      if (in_valid && in_ready) n++;
      @(posedge clk);
      #1;
      cycles++;
    end
    chk("tp_words", n, 1200);
    chk("tp_elements", n_out - n0, 300);
    chk("tp_lasts", n_last - l0, 100);
    chk("tp_cycles_bound", cycles <= 1205, 1'b1);
    chk("tp_err_clean", err_msb, 1'b0);
`ifdef PACKER_STATS_EN
    chk("tp_pkt_count", pkt_count, 16'd100);
`endif

    // Reset in the middle of element 1.
    for (int k = 0; k < 4; k++) cyc(1'b1, tw(0, k), 1'b1);
    cyc(1'b1, tw(1, 0), 1'b1);
    cyc(1'b1, tw(1, 1), 1'b1);
    resetn    = 1'b0;
    in_valid  = 1'b1;
    in_data   = 64'h8000_0000_0000_0000;
    out_ready = 1'b1;
    #1;
    chk("mid_rst_in_ready", in_ready, 1'b0);
    @(posedge clk);
    #1;
    chk("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_out_last", out_last, 1'b0);
    chk("mid_rst_payload", out_payload, '0);
    chk("mid_rst_err", err_msb, 1'b0);
`ifdef PACKER_STATS_EN
    chk("mid_rst_pkt_count", pkt_count, '0);
`endif
    resetn = 1'b1;
    n0 = n_out;
    l0 = n_last;
    for (int i = 0; i < 12; i++) begin
      cyc(1'b1, bw(i / 4, i % 4), 1'b1);
      if (i % 4 == 3) chk("mid_rst_last_flag", out_last, (i == 11));
    end
    cyc(1'b0, 64'd0, 1'b1);
    chk("mid_rst_elements", n_out - n0, 3);
    chk("mid_rst_lasts", n_last - l0, 1);
`ifdef PACKER_STATS_EN
    chk("mid_rst_pkt_after", pkt_count, 16'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
